// File: rtl/fifo_rd_stream.sv
// ============================================================================
// fifo_rd_stream : read-side drain engine, FIFO read port to valid/ready stream
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
    parameter int G_WIDTH = 8,
    parameter int G_CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_arstN,
    input  logic               i_empty,
    input  logic [G_WIDTH-1:0] i_fifo_data,
    output logic               o_ren,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [G_WIDTH-1:0] o_data,
    output logic [1:0]         o_occ,
    output logic [G_CNT_W-1:0] o_count
);

    logic [G_WIDTH-1:0] mem_q [3];
    logic [1:0]         wptr_q, wptr_d;
    logic [1:0]         rptr_q, rptr_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [G_CNT_W-1:0] count_q, count_d;

    logic               w_room;
    logic               w_capture;
    logic               w_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued if its word is guaranteed a slot, counting the one
    // already in flight; this keeps i_ready out of the o_ren path entirely.
    always_comb begin
        w_room    = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
        o_ren     = i_arstN && !i_empty && !i_flush && w_room;
        w_capture = inflight_q && !i_flush;
        w_pop     = (occ_q != 2'd0) && i_ready;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        count_d    = count_q;

        if (w_pop) begin
            rptr_d  = ptr_inc(rptr_q);
            count_d = count_q + G_CNT_W'(1);
        end

        if (i_flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            wptr_d     = 2'd0;
            rptr_d     = 2'd0;
        end else begin
            inflight_d = o_ren;
            if (w_capture) begin
                wptr_d = ptr_inc(wptr_q);
            end
            case ({w_capture, w_pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arstN) begin
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (w_capture) begin
                mem_q[wptr_q] <= i_fifo_data;
            end
        end
    end

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = mem_q[rptr_q];
    assign o_occ   = occ_q;
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// tb_fifo_rd_stream : self-checking bench, queue-based reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        i_arstN = 1'b0;
    logic        i_empty = 1'b1;
    logic [7:0]  i_fifo_data = '0;
    logic        o_ren;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [7:0]  o_data;
    logic [1:0]  o_occ;
    logic [15:0] o_count;

    fifo_rd_stream #(.G_WIDTH(8), .G_CNT_W(16)) u_dut (
        .i_clk       (clk),
        .i_arstN     (i_arstN),
        .i_empty     (i_empty),
        .i_fifo_data (i_fifo_data),
        .o_ren       (o_ren),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_occ       (o_occ),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO contents, stream buffer as a queue, one in-flight word
    logic [7:0]  fifo_q[$];
    logic [7:0]  m_buf[$];
    bit          m_infl = 1'b0;
    logic [7:0]  m_infl_word = '0;
    int unsigned m_cnt = 0;

    bit          seq_on = 1'b0;
    int          seq_n = 0;
    bit          chk_zero = 1'b0;
    bit          hs_seen = 1'b0;
    logic [7:0]  last_hs_data;
    int          cyc = 0;
    int          first_ren = -1;
    int          first_val = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, compare DUT to model, advance the model across the edge
    task automatic step(input logic rdy, input logic fl, input logic rn);
        bit exp_ren, pop;
        @(negedge clk);
        i_fifo_data = m_infl ? m_infl_word : 8'($urandom);
        i_ready     = rdy;
        i_flush     = fl;
        i_arstN     = rn;
        i_empty     = (fifo_q.size() == 0);
        #1;
        exp_ren = rn && (fifo_q.size() != 0) && !fl && ((m_buf.size() + int'(m_infl)) < 3);
        chk("ren",   o_ren,   exp_ren);
        chk("valid", o_valid, m_buf.size() != 0);
        chk("occ",   o_occ,   m_buf.size());
        chk("count", o_count, m_cnt[15:0]);
        if (m_buf.size() != 0) chk("data", o_data, m_buf[0]);
        if (chk_zero) chk("rst_data", o_data, 0);
        if (first_ren < 0 && o_ren)   first_ren = cyc;
        if (first_val < 0 && o_valid) first_val = cyc;
        cyc++;

        pop = rn && (m_buf.size() != 0) && rdy;
        if (!rn) begin
            m_buf.delete();
            m_infl = 1'b0;
            m_cnt  = 0;
        end else begin
            if (pop) begin
                if (seq_on) begin
                    chk("order", o_data, 32'(seq_n[7:0]));
                    seq_n++;
                end
                hs_seen      = 1'b1;
                last_hs_data = m_buf.pop_front();
                m_cnt++;
            end
            if (fl) begin
                m_buf.delete();
                m_infl = 1'b0;
            end else begin
                if (m_infl) begin
                    chk("cap_room", (o_occ != 2'd3) || pop, 1);
                    m_buf.push_back(m_infl_word);
                end
                m_infl = exp_ren;
                if (exp_ren) m_infl_word = fifo_q.pop_front();
            end
        end
    endtask

    initial begin
        logic [7:0] nxt;
        int guard;

        i_arstN = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset with an empty FIFO
        chk_zero = 1'b1;
        step(0, 0, 1);
        chk_zero = 1'b0;
        for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), 0, 1);

        // Four words, sink always ready
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        first_ren = -1;
        first_val = -1;
        for (int i = 0; i < 8; i++) step(1, 0, 1);
        chk("latency", first_val - first_ren, 2);
        chk("cnt4", o_count, 4);
        chk("occ_idle", o_occ, 0);

        // Four words, sink stalled then released
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        chk("stall_occ", o_occ, 3);
        chk("stall_data", o_data, 8'h11);
        chk("stall_ren", o_ren, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1);
        chk("cnt8", o_count, 8);

        // Flush with two buffered words and one in flight
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
        guard = 0;
        while (!(m_buf.size() == 2 && m_infl) && guard < 10) begin
            step(0, 0, 1);
            guard++;
        end
        nxt = fifo_q[0];
        step(1, 1, 1);
        hs_seen      = 1'b0;
        last_hs_data = 'x;
        step(1, 0, 1);
        chk("flush_valid", o_valid, 0);
        chk("flush_occ", o_occ, 0);
        guard = 0;
        while (!hs_seen && guard < 10) begin
            step(1, 0, 1);
            guard++;
        end
        chk("flush_next", last_hs_data, nxt);
        for (int i = 0; i < 10; i++) step(1, 0, 1);

        // Reset mid-stream with a full buffer and a pending handshake
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hC0 + 8'(i));
        guard = 0;
        while (m_buf.size() != 3 && guard < 10) begin
            step(0, 0, 1);
            guard++;
        end
        step(1, 0, 0);
        chk_zero = 1'b1;
        step(0, 0, 1);
        chk_zero = 1'b0;
        chk("rst_cnt", o_count, 0);
        chk("rst_occ", o_occ, 0);

        // 1000 sequential words against a randomly stalling sink
        fifo_q.delete();
        step(0, 0, 0);
        for (int i = 0; i < 1000; i++) fifo_q.push_back(8'(i));
        seq_on = 1'b1;
        seq_n  = 0;
        guard  = 0;
        while (seq_n < 1000 && guard < 6000) begin
            step(1'($urandom_range(0, 1)), 0, 1);
            guard++;
        end
        seq_on = 1'b0;
        chk("rand_done", seq_n, 1000);
        step(0, 0, 1);
        chk("rand_cnt", o_count, 1000);
        chk("rand_occ", o_occ, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO.
- Sits entirely in the FIFO read clock domain. Drives the FIFO read enable, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream.
- A 3-entry skid buffer sustains 1 word/cycle with no combinational path from i_ready to o_ren.
- Also provides a synchronous flush and a delivered-word counter.

Parameters:
- G_WIDTH, 8, data word width; must equal the FIFO G_WIDTH.
- G_CNT_W, 16, width of the delivered-word counter.

Ports:
- i_clk  in  1  read-domain clock; all logic on rising edge.
- i_arstN  in  1  reset, synchronous, active-low.
- i_empty  in  1  FIFO empty flag (registered in the FIFO).
- i_fifo_data  in  G_WIDTH  FIFO read data; valid in the cycle after an accepted read.
- o_ren  out  1  FIFO read enable.
- i_flush  in  1  synchronous discard of buffered and in-flight words.
- o_valid  out  1  stream data valid.
- i_ready  in  1  stream sink ready.
- o_data  out  G_WIDTH  stream data (head of buffer).
- o_occ  out  2  buffer occupancy, 0..3.
- o_count  out  G_CNT_W  words delivered (valid&&ready handshakes), wraps modulo 2^G_CNT_W.

Behaviour:
- Reset: sampled on the rising edge with i_arstN low.
  - Clears: o_occ=0, inflight=0, o_count=0, o_valid=0, o_data=0, read/write pointers=0.
  - o_ren is forced 0 combinationally while i_arstN is low.
  - Reset asserted mid-transfer drops all buffered and in-flight words; no handshake completes on that edge.
- Internal state:
  - 3-entry buffer, circular write/read pointers in range 0..2.
  - occ register, 0..3.
  - inflight flag: a read was issued in the previous cycle.
- o_ren = !i_empty && !i_flush && (occ + inflight < 3) && i_arstN.
  - Depends only on registers and i_empty. It does not depend on i_ready.
- Issue: o_ren=1 in cycle t sets inflight=1 for cycle t+1.
- Capture: in any cycle with inflight=1 and i_flush=0, i_fifo_data is written to buffer[wptr] at the end of that cycle, and wptr advances (wraps 2→0).
- Pop: o_valid = (occ != 0); o_data = buffer[rptr]. When o_valid && i_ready, rptr advances (wraps) and o_count increments.
- Occupancy update: occ_next = occ + capture − pop. Capture and pop in the same cycle leave occ unchanged. Capture with occ=3 cannot happen because of the o_ren gating; the bench asserts this.
- Ordering: words are delivered in strictly the order they were read from the FIFO. No duplication, no loss except via flush or reset.
- Stream rules:
  - Once o_valid=1, o_data is held stable until the handshake.
  - o_valid never drops without a handshake, except on flush or reset.
- Throughput: with i_empty=0 and i_ready=1 continuously, steady state is occ=1, inflight=1, o_ren=1 every cycle, and 1 word per cycle is delivered.
- Latency: from first o_ren (cycle t), o_valid=1 in cycle t+2.
- Flush: i_flush=1 in cycle t:
  - o_ren=0 in cycle t.
  - Any capture in cycle t is suppressed.
  - A handshake in cycle t still counts.
  - At end of cycle t: occ=0, inflight=0, pointers=0.
  - o_valid=0 in cycle t+1.
- i_empty is treated as authoritative. A read is never issued while i_empty=1. The FIFO suppresses reads when empty regardless.

Test Plan:
- Reset then idle, i_empty=1 for 10 cycles -> o_ren=0, o_valid=0, o_occ=0, o_count=0 throughout.
- FIFO holds 0x11,0x22,0x33,0x44; i_ready=1 constantly -> o_ren high on 4 consecutive cycles; o_valid first in cycle t+2; o_data 0x11,0x22,0x33,0x44 on consecutive cycles; o_count=4; o_occ returns to 0.
- Same 4 words, i_ready=0 -> o_ren stops after 3 reads, o_occ=3, o_data=0x11 held stable. Then i_ready=1 -> 0x11..0x44 in order with no gaps beyond one cycle; 0x44 read only after occupancy permits.
- Random i_ready (50%) with 1000 sequential words -> scoreboard order exact; o_occ never exceeds 3; capture never occurs with occ=3; o_count=1000 mod 2^16.
- i_flush asserted while o_occ=2 and inflight=1 -> next cycle o_valid=0, o_occ=0; the in-flight word is discarded; the next delivered word is the FIFO's subsequent word.
- i_arstN low for one cycle mid-stream, with occ=3 and a pending handshake -> all state cleared on that edge; o_count=0; the handshake is not counted; o_ren=0 during the reset cycle.
